// File: rtl/majority_vote_controller_if.sv
// Voter / consumer bundle for majority_vote_controller.
// The master side issues start, votes and result_ready; the slave side is the controller.
interface majority_vote_controller_if #(
   parameter int NUM_VOTERS = 5,
   parameter int CW         = 3
);
   logic                  start;
   logic [NUM_VOTERS-1:0] vote_valid;
   logic [NUM_VOTERS-1:0] vote_value;
   logic [NUM_VOTERS-1:0] vote_ack;
   logic                  busy;
   logic                  result_valid;
   logic                  result_ready;
   logic                  result;
   logic [CW-1:0]         vote_count;
   logic                  quorum_met;
   logic                  timeout_flag;

   modport master (
      output start, vote_valid, vote_value, result_ready,
      input  vote_ack, busy, result_valid, result, vote_count, quorum_met, timeout_flag
   );

   modport slave (
      input  start, vote_valid, vote_value, result_ready,
      output vote_ack, busy, result_valid, result, vote_count, quorum_met, timeout_flag
   );
endinterface

// File: rtl/majority_vote_controller.sv
// Runs one voting round across NUM_VOTERS requesters, closes it on full quorum or timeout,
// and holds the strict-majority decision on a valid/ready handshake.
module majority_vote_controller #(
   parameter int NUM_VOTERS = 5,
   parameter int TIMEOUT    = 16,
   parameter int CW         = 3,
   parameter int TW         = 5
) (
   input  logic                       clk,
   input  logic                       rst_n,
   majority_vote_controller_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, EVAL, RESULT} state_t;

   localparam logic [CW-1:0] HALF   = CW'(NUM_VOTERS / 2);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [NUM_VOTERS-1:0] voted, yes, accept, ack_q;
   logic [TW-1:0]         timer;
   logic                  rv_q, result_q, quorum_q, timeout_q;
   logic [CW-1:0]         count_q;

   function automatic logic [CW-1:0] popcount(input logic [NUM_VOTERS-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_VOTERS; i++) n = n + CW'(v[i]);
      return n;
   endfunction

   always_comb begin
      state_nxt = state;
      accept    = '0;
      case (state)
         IDLE:    if (bus.start) state_nxt = COLLECT;
         COLLECT: begin
            // First vote per voter wins; later strobes from the same voter are dropped.
            accept = bus.vote_valid & ~voted;
            if ((voted | accept) == '1)  state_nxt = EVAL;
            else if (timer == T_LAST)    state_nxt = EVAL;
         end
         EVAL:    state_nxt = RESULT;
         RESULT:  if (rv_q && bus.result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         voted     <= '0;
         yes       <= '0;
         timer     <= '0;
         ack_q     <= '0;
         rv_q      <= 1'b0;
         result_q  <= 1'b0;
         count_q   <= '0;
         quorum_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state <= state_nxt;
         ack_q <= accept;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  voted <= '0;
                  yes   <= '0;
                  timer <= '0;
               end
            end
            COLLECT: begin
               voted <= voted | accept;
               yes   <= yes | (accept & bus.vote_value);
               timer <= timer + 1'b1;
            end
            EVAL: begin
               // Missing voters sit at 0 in the yes mask, so they count against the motion.
               count_q   <= popcount(yes);
               result_q  <= (popcount(yes) > HALF);
               quorum_q  <= &voted;
               timeout_q <= ~(&voted);
               rv_q      <= 1'b1;
            end
            RESULT: begin
               if (bus.result_ready) rv_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.vote_ack     = ack_q;
   assign bus.busy         = (state != IDLE);
   assign bus.result_valid = rv_q;
   assign bus.result       = result_q;
   assign bus.vote_count   = count_q;
   assign bus.quorum_met   = quorum_q;
   assign bus.timeout_flag = timeout_q;
endmodule

// File: tb/tb_majority_vote_controller.sv
// Scoreboard bench for majority_vote_controller: directed and random rounds are
// predicted from the voting rules and compared by an independent monitor.
module tb_majority_vote_controller;
   localparam int NV      = 5;
   localparam int TIMEOUT = 16;
   localparam int NONE    = 99;

   typedef struct packed {
      logic            res;
      logic [2:0]      cnt;
      logic            q;
      logic            tf;
      logic [7:0]      lat;
      logic [4:0][7:0] ack_lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cycle = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ready_mode = 0;

   exp_t sb[$];
   int   plan_off [NV];
   int   plan_rep [NV];
   logic [NV-1:0] plan_val, plan_rval;

   majority_vote_controller_if #(.NUM_VOTERS(NV), .CW(3)) bus();

   majority_vote_controller #(.NUM_VOTERS(NV), .TIMEOUT(TIMEOUT), .CW(3), .TW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cycle);
      end
   endtask

   // ---------------- monitor ----------------
   logic       prev_busy = 1'b0, prev_rv = 1'b0, hs_prev = 1'b0;
   int         t_busy = 0;
   logic [7:0] ack_seen [NV];
   exp_t       cur;
   logic       h_res, h_q, h_tf;
   logic [2:0] h_cnt;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_busy = 1'b0;
         prev_rv   = 1'b0;
         hs_prev   = 1'b0;
      end else begin
         if (hs_prev) begin
            chk("busy_low_after_handshake", bus.busy, 0);
            chk("valid_low_after_handshake", bus.result_valid, 0);
         end
         if (bus.busy && !prev_busy) begin
            t_busy = cycle;
            for (int i = 0; i < NV; i++) ack_seen[i] = 8'hFF;
         end
         for (int i = 0; i < NV; i++) begin
            if (bus.vote_ack[i]) begin
               chk("ack_only_while_busy", bus.busy, 1);
               chk("single_ack_per_voter", (ack_seen[i] == 8'hFF), 1);
               ack_seen[i] = 8'(cycle - t_busy);
            end
         end
         if (bus.result_valid && !prev_rv) begin
            chk("scoreboard_has_entry", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               cur = sb[0];
               chk("result_latency", 8'(cycle - t_busy), cur.lat);
               for (int i = 0; i < NV; i++) chk("ack_timing", ack_seen[i], cur.ack_lat[i]);
            end
            h_res = bus.result; h_cnt = bus.vote_count; h_q = bus.quorum_met; h_tf = bus.timeout_flag;
         end else if (bus.result_valid) begin
            chk("hold_result", bus.result, h_res);
            chk("hold_vote_count", bus.vote_count, h_cnt);
            chk("hold_quorum", bus.quorum_met, h_q);
            chk("hold_timeout", bus.timeout_flag, h_tf);
            chk("busy_while_result", bus.busy, 1);
         end
         if (bus.result_valid && bus.result_ready) begin
            if (sb.size() > 0) begin
               cur = sb.pop_front();
               chk("result", bus.result, cur.res);
               chk("vote_count", bus.vote_count, cur.cnt);
               chk("quorum_met", bus.quorum_met, cur.q);
               chk("timeout_flag", bus.timeout_flag, cur.tf);
            end
            hs_prev = 1'b1;
         end else begin
            hs_prev = 1'b0;
         end
         prev_busy = bus.busy;
         prev_rv   = bus.result_valid;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (ready_mode == 0) bus.result_ready = ($urandom_range(0, 2) != 0);
   endtask

   task automatic set_ready(input int m);
      ready_mode = m;
      if (m == 1) bus.result_ready = 1'b0;
      if (m == 2) bus.result_ready = 1'b1;
   endtask

   // Reference: a voter counts iff its first vote lands inside the round window.
   function automatic exp_t predict();
      exp_t e;
      bit   all_in;
      int   close_off, cnt;
      all_in = 1'b1;
      close_off = 0;
      for (int i = 0; i < NV; i++) begin
         if (plan_off[i] >= TIMEOUT) all_in = 1'b0;
         else if (plan_off[i] > close_off) close_off = plan_off[i];
      end
      if (!all_in) close_off = TIMEOUT - 1;
      cnt = 0;
      for (int i = 0; i < NV; i++) begin
         if (plan_off[i] <= close_off) begin
            cnt += int'(plan_val[i]);
            e.ack_lat[i] = 8'(plan_off[i] + 1);
         end else begin
            e.ack_lat[i] = 8'hFF;
         end
      end
      e.res = (cnt > NV / 2);
      e.cnt = 3'(cnt);
      e.q   = all_in;
      e.tf  = !all_in;
      e.lat = 8'(close_off + 2);
      return e;
   endfunction

   task automatic drive_offset(input int o);
      for (int i = 0; i < NV; i++) begin
         bus.vote_valid[i] = (plan_off[i] == o) || (plan_rep[i] == o);
         bus.vote_value[i] = (plan_off[i] == o) ? plan_val[i] : plan_rval[i];
      end
   endtask

   task automatic launch_round(input int last_off);
      bus.vote_valid = '0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int o = 0; o <= last_off; o++) begin
         drive_offset(o);
         step();
      end
      bus.vote_valid = '0;
      bus.vote_value = '0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200 && bus.busy; k++) step();
      chk("round_completes", bus.busy, 0);
   endtask

   task automatic full_round();
      sb.push_back(predict());
      launch_round(TIMEOUT + 1);
      wait_idle();
      step();
   endtask

   task automatic clear_plan();
      for (int i = 0; i < NV; i++) begin
         plan_off[i] = NONE;
         plan_rep[i] = NONE;
      end
      plan_val  = '0;
      plan_rval = '0;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_result_valid"}, bus.result_valid, 0);
      chk({tag, "_vote_ack"}, bus.vote_ack, 0);
      chk({tag, "_result"}, bus.result, 0);
      chk({tag, "_vote_count"}, bus.vote_count, 0);
      chk({tag, "_quorum_met"}, bus.quorum_met, 0);
      chk({tag, "_timeout_flag"}, bus.timeout_flag, 0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.vote_valid = '0;
      bus.vote_value = '0;
      bus.result_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) step();
      check_zero_outputs("reset");
      rst_n = 1'b1;
      step();

      // Ignored votes in IDLE
      bus.vote_valid = 5'b10101; bus.vote_value = 5'b11111;
      step(); step();
      bus.vote_valid = '0;
      chk("idle_votes_no_busy", bus.busy, 0);

      // 1: everyone at once
      clear_plan();
      for (int i = 0; i < NV; i++) plan_off[i] = 0;
      plan_val = 5'b00111;
      full_round();

      // 2: one voter per cycle
      clear_plan();
      for (int i = 0; i < NV; i++) plan_off[i] = i;
      plan_val = 5'b00011;
      full_round();

      // 3: timeout with three yes votes
      clear_plan();
      plan_off[0] = 0; plan_off[1] = 1; plan_off[2] = 2;
      plan_val = 5'b00111;
      full_round();

      // 4: repeat vote from voter 0 ignored
      clear_plan();
      plan_off[0] = 0; plan_rep[0] = 2; plan_rval[0] = 1'b0;
      for (int i = 1; i < NV; i++) plan_off[i] = i;
      plan_val = 5'b00111;
      full_round();

      // 5: consumer stalls with start pulses; start on the handshake cycle is ignored
      clear_plan();
      for (int i = 0; i < NV; i++) plan_off[i] = 0;
      plan_val = 5'b11010;
      set_ready(1);
      sb.push_back(predict());
      launch_round(2);
      for (int k = 0; k < 10; k++) begin
         bus.start = k[0];
         step();
      end
      chk("stall_result_valid", bus.result_valid, 1);
      chk("stall_busy", bus.busy, 1);
      bus.start = 1'b1;
      set_ready(2);
      step();
      bus.start = 1'b0;
      set_ready(0);
      step();
      chk("start_on_handshake_ignored", bus.busy, 0);

      // 6: reset mid-round, then a single-yes timeout round
      clear_plan();
      plan_off[0] = 0; plan_off[1] = 1;
      plan_val = 5'b00011;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int o = 0; o < 3; o++) begin
         drive_offset(o);
         step();
      end
      bus.vote_valid = '0;
      rst_n = 1'b0;
      step();
      check_zero_outputs("midround_reset");
      rst_n = 1'b1;
      step();
      clear_plan();
      plan_off[0] = 0;
      plan_val = 5'b00001;
      full_round();

      // Random rounds
      for (int r = 0; r < 24; r++) begin
         clear_plan();
         plan_val  = 5'($urandom);
         plan_rval = 5'($urandom);
         for (int i = 0; i < NV; i++) begin
            if ($urandom_range(0, 4) != 0) plan_off[i] = $urandom_range(0, (r < 12) ? 6 : TIMEOUT + 1);
            if (plan_off[i] != NONE && $urandom_range(0, 1) == 1) plan_rep[i] = plan_off[i] + $urandom_range(1, 4);
         end
         bus.vote_valid = 5'($urandom);
         bus.vote_value = 5'($urandom);
         step();
         full_round();
      end

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/majority_vote_controller.md
Name: majority_vote_controller

Overview:
Sequences one voting round across NUM_VOTERS independent requesters and feeds the collected votes to a strict-majority decision.
- Each requester submits one vote per round using a valid/ack strobe.
- The round closes when every voter has voted, or when the timeout expires.
- The result is held on a valid/ready handshake until the consumer accepts it.
- The block sits between distributed voters (redundant channels, sensors) and downstream decision logic.

Parameters:
NUM_VOTERS, 5, number of voters; width of the per-voter vectors
TIMEOUT, 16, maximum number of COLLECT cycles per round (must be >= 1)
CW, 3, width of vote_count; must hold the value NUM_VOTERS
TW, 5, width of the internal timer; must hold the value TIMEOUT

Ports:
clk  input  1  single clock; all logic is on the rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  requests a new round; honoured only in IDLE
vote_valid  input  NUM_VOTERS  per-voter vote strobe
vote_value  input  NUM_VOTERS  per-voter vote bit (1 = yes); sampled when the matching vote_valid bit is high
vote_ack  output  NUM_VOTERS  registered one-cycle pulse per accepted vote
busy  output  1  high whenever state is not IDLE
result_valid  output  1  a result is available
result_ready  input  1  consumer accepts the result
result  output  1  majority decision
vote_count  output  CW  number of yes votes in the last round
quorum_met  output  1  all voters voted before the timeout
timeout_flag  output  1  round closed by timeout

Behaviour:
Reset:
- Synchronous, active-low, on clk.
- State goes to IDLE.
- All outputs go to 0; voted/yes masks and the timer are cleared.
- Reset mid-round discards all votes collected so far.

State machine (IDLE, COLLECT, EVAL, RESULT; registered):
IDLE:
- busy = 0.
- If start = 1: go to COLLECT on the next cycle; clear the voted mask, yes mask and timer.
COLLECT:
- Each cycle, for every i with vote_valid[i] = 1 and voted[i] = 0: set voted[i] = 1, yes[i] = vote_value[i], and vote_ack[i] = 1 on the following cycle only.
- Repeat votes from a voter that has already voted are ignored; no ack is generated.
- The timer increments every COLLECT cycle.
- Exit to EVAL when the voted mask, including votes accepted this cycle, is all ones. This takes priority.
- Otherwise exit to EVAL when timer = TIMEOUT-1.
EVAL (exactly one cycle):
- vote_count <= popcount(yes).
- result <= 1 iff vote_count > NUM_VOTERS/2 (integer division); voters that did not vote count as 0. With 5 voters, 3 or more yes gives 1.
- quorum_met <= all voted; timeout_flag <= ~quorum_met.
- result_valid <= 1; go to RESULT.
RESULT:
- result_valid stays high until a cycle with result_valid & result_ready; the transfer happens in that cycle.
- On the next cycle result_valid = 0 and state = IDLE.
- result, vote_count, quorum_met and timeout_flag hold their values until the next EVAL.

Ignored inputs and simultaneous events:
- start while busy is ignored.
- vote_valid in IDLE, EVAL or RESULT is ignored, with no ack.
- Several voters may vote in the same cycle; all of them are accepted.
- start in the same cycle as the RESULT handshake is ignored; start must be reasserted in IDLE.

Latency:
- start at cycle 0, COLLECT at cycle 1.
- If all votes arrive at cycle 1: EVAL at cycle 2, result_valid high at cycle 3.
- Timeout round: result_valid is high TIMEOUT+2 cycles after start.

Test Plan:
1. start; all 5 vote_valid at the first COLLECT cycle, vote_value = 5'b00111 -> vote_ack = 5'b11111 for one cycle; result_valid at start+3; result = 1, vote_count = 3, quorum_met = 1, timeout_flag = 0.
2. Votes 5'b00011 spread one voter per cycle -> five single-bit acks; result = 0, vote_count = 2, quorum_met = 1.
3. Only voters 0-2 vote yes, TIMEOUT = 16 -> round closes after 16 COLLECT cycles; result = 1, vote_count = 3, quorum_met = 0, timeout_flag = 1.
4. Voter 0 votes 1, then votes 0 two cycles later -> a single ack only; first vote kept; with the others voting 5'b00110 in bits 4:1, vote_count = 3, result = 1.
5. result_ready held low 10 cycles while start pulses -> result_valid and all result fields stay stable, busy = 1; after the ready handshake, busy = 0 on the next cycle.
6. rst_n low during COLLECT after 2 yes votes -> all outputs 0, state IDLE; in a new round with only 1 yes vote plus timeout -> vote_count = 1, result = 0.
